// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read-channel arbiter with one burst in flight.
// An IDLE cycle picks a winner, ADDR forwards its AR beat and DATA routes the
// R beats back to it. The granted master index is prepended to the slave ARID.
// Define ARB_RR_EN for round-robin arbitration; otherwise M0 has fixed priority.
module axi_read_arbiter #(
  parameter int unsigned MID_W  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // Master 0
  input  logic [MID_W-1:0]    M0_ARID,
  input  logic [ADDR_W-1:0]   M0_ARAddr,
  input  logic [3:0]          M0_ARLen,
  input  logic [2:0]          M0_ARSize,
  input  logic [1:0]          M0_ARBurst,
  input  logic                M0_ARValid,
  output logic                M0_ARReady,
  output logic [MID_W-1:0]    M0_RID,
  output logic [DATA_W-1:0]   M0_RData,
  output logic [1:0]          M0_RResp,
  output logic                M0_RLast,
  output logic                M0_RValid,
  input  logic                M0_RReady,
  // Master 1
  input  logic [MID_W-1:0]    M1_ARID,
  input  logic [ADDR_W-1:0]   M1_ARAddr,
  input  logic [3:0]          M1_ARLen,
  input  logic [2:0]          M1_ARSize,
  input  logic [1:0]          M1_ARBurst,
  input  logic                M1_ARValid,
  output logic                M1_ARReady,
  output logic [MID_W-1:0]    M1_RID,
  output logic [DATA_W-1:0]   M1_RData,
  output logic [1:0]          M1_RResp,
  output logic                M1_RLast,
  output logic                M1_RValid,
  input  logic                M1_RReady,
  // Slave
  output logic [MID_W+3:0]    S_ARID,
  output logic [ADDR_W-1:0]   S_ARAddr,
  output logic [3:0]          S_ARLen,
  output logic [2:0]          S_ARSize,
  output logic [1:0]          S_ARBurst,
  output logic                S_ARValid,
  input  logic                S_ARReady,
  input  logic [MID_W+3:0]    S_RID,
  input  logic [DATA_W-1:0]   S_RData,
  input  logic [1:0]          S_RResp,
  input  logic                S_RLast,
  input  logic                S_RValid,
  output logic                S_RReady,
  output logic                len_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_q, beat_d;

  logic        any_req;
  logic        winner;
  logic        ar_hs;
  logic        r_hs;
  logic        unused_rid;

  // Routing bits of the slave ID are not returned to the masters.
  assign unused_rid = ^S_RID[MID_W+3:MID_W];

  assign any_req = M0_ARValid | M1_ARValid;

  assign ar_hs = (state_q == StAddr) & S_ARReady & (grant_q ? M1_ARValid : M0_ARValid);
  assign r_hs  = (state_q == StData) & S_RValid & (grant_q ? M1_RReady : M0_RReady);

  // Arbitration among simultaneous requests; a lone requester always wins.
  always_comb begin
    winner = M1_ARValid & ~M0_ARValid;
`ifdef ARB_RR_EN
    if (M0_ARValid && M1_ARValid) winner = ~last_grant_q;
`else
    if (M0_ARValid && M1_ARValid) winner = 1'b0;
`endif
  end

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state; the slave's RLast alone ends a burst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StAddr;
      StAddr:  if (ar_hs) state_d = StData;
      StData:  if (r_hs && S_RLast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next-state logic for grant, burst length and beat counter.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_d       = beat_q;
    if (state_q == StIdle && any_req) grant_d = winner;
    if (ar_hs) begin
      len_d  = grant_q ? M1_ARLen : M0_ARLen;
      beat_d = 4'd0;
    end
    if (r_hs) begin
      beat_d = beat_q + 4'd1;
      if (S_RLast) last_grant_d = grant_q;
    end
  end

  // Datapath registers; reset makes the arbiter behave as if M1 was last served.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= 4'd0;
      beat_q       <= 4'd0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
    end
  end

  // Output routing; everything is zero outside the state that owns the channel.
  always_comb begin
    M0_ARReady = 1'b0;
    M1_ARReady = 1'b0;
    M0_RID     = '0;
    M0_RData   = '0;
    M0_RResp   = '0;
    M0_RLast   = 1'b0;
    M0_RValid  = 1'b0;
    M1_RID     = '0;
    M1_RData   = '0;
    M1_RResp   = '0;
    M1_RLast   = 1'b0;
    M1_RValid  = 1'b0;
    S_ARID     = '0;
    S_ARAddr   = '0;
    S_ARLen    = '0;
    S_ARSize   = '0;
    S_ARBurst  = '0;
    S_ARValid  = 1'b0;
    S_RReady   = 1'b0;
    len_err    = 1'b0;
    unique case (state_q)
      StAddr: begin
        if (grant_q) begin
          S_ARID     = {3'b000, 1'b1, M1_ARID};
          S_ARAddr   = M1_ARAddr;
          S_ARLen    = M1_ARLen;
          S_ARSize   = M1_ARSize;
          S_ARBurst  = M1_ARBurst;
          S_ARValid  = M1_ARValid;
          M1_ARReady = S_ARReady;
        end else begin
          S_ARID     = {3'b000, 1'b0, M0_ARID};
          S_ARAddr   = M0_ARAddr;
          S_ARLen    = M0_ARLen;
          S_ARSize   = M0_ARSize;
          S_ARBurst  = M0_ARBurst;
          S_ARValid  = M0_ARValid;
          M0_ARReady = S_ARReady;
        end
      end
      StData: begin
        if (grant_q) begin
          M1_RID    = S_RID[MID_W-1:0];
          M1_RData  = S_RData;
          M1_RResp  = S_RResp;
          M1_RLast  = S_RLast;
          M1_RValid = S_RValid;
          S_RReady  = M1_RReady;
        end else begin
          M0_RID    = S_RID[MID_W-1:0];
          M0_RData  = S_RData;
          M0_RResp  = S_RResp;
          M0_RLast  = S_RLast;
          M0_RValid = S_RValid;
          S_RReady  = M0_RReady;
        end
        // Flag a beat count that disagrees with the slave's RLast.
        len_err = r_hs & (S_RLast ? (beat_q != len_q) : (beat_q == len_q));
      end
      default: ;
    endcase
  end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter MID_W, default 4: master-side ID width; slave-side ID width is MID_W+4.
REQ-002 Parameter ADDR_W, default 32: address width, `AXI_ADDR_BITS.
REQ-003 Parameter DATA_W, default 32: data width, `AXI_DATA_BITS.
REQ-004 ACLK  in  1  sole clock; all state updates on rising edge.
REQ-005 ARESETn  in  1  reset; asynchronous assert, active-low, synchronous deassert handled outside block.
REQ-006 M0_ARID/M1_ARID  in  MID_W  per-master read ID.
REQ-007 M0_ARAddr/M1_ARAddr  in  ADDR_W  per-master read address.
REQ-008 M0_ARLen/M1_ARLen  in  4  burst length minus one; M0_ARSize/M1_ARSize in 3; M0_ARBurst/M1_ARBurst in 2.
REQ-009 M0_ARValid/M1_ARValid  in  1; M0_ARReady/M1_ARReady  out  1  per-master AR handshake.
REQ-010 M0_RID/M1_RID  out  MID_W; M0_RData/M1_RData  out  DATA_W; M0_RResp/M1_RResp  out  2; M0_RLast/M1_RLast  out  1.
REQ-011 M0_RValid/M1_RValid  out  1; M0_RReady/M1_RReady  in  1  per-master R handshake.
REQ-012 S_ARID  out  MID_W+4; S_ARAddr  out  ADDR_W; S_ARLen  out  4; S_ARSize  out  3; S_ARBurst  out  2; S_ARValid  out  1; S_ARReady  in  1.
REQ-013 S_RID  in  MID_W+4; S_RData  in  DATA_W; S_RResp  in  2; S_RLast, S_RValid  in  1; S_RReady  out  1.
REQ-014 len_err  out  1  one-cycle pulse on burst-length mismatch.

Function
REQ-015 FSM states: IDLE, ADDR, DATA; reset state IDLE.
REQ-016 IDLE: if any M*_ARValid, latch grant (1 bit) and move to ADDR next cycle; no request leaves FSM in IDLE.
REQ-017 Both masters requesting in IDLE: winner chosen per REQ-034/035.
REQ-018 ADDR: S_AR* payload = granted master's AR*; S_ARID = {4'(grant), granted ARID}; S_ARValid = granted ARValid.
REQ-019 ADDR: granted M*_ARReady = S_ARReady (combinational); non-granted ARReady = 0 in all states.
REQ-020 ADDR: on S_ARValid&S_ARReady, latch ARLen into len_reg, clear beat counter, move to DATA.
REQ-021 Granted master dropping ARValid in ADDR (protocol violation) is not handled; FSM holds ADDR.
REQ-022 DATA: granted M*_R* = S_R*, with RID = S_RID[MID_W-1:0]; S_RReady = granted M*_RReady; non-granted RValid = 0.
REQ-023 Outside DATA: S_RReady = 0, all M*_RValid = 0.
REQ-024 Each R handshake in DATA increments 4-bit beat counter; wrap at 15 is not reachable for legal bursts.
REQ-025 R handshake with S_RLast=1: FSM to IDLE next cycle, last_grant <= grant.
REQ-026 len_err pulses one cycle when S_RLast=1 handshake occurs with beat counter != len_reg, or beat counter == len_reg handshake occurs with S_RLast=0; FSM follows S_RLast only.
REQ-027 One outstanding burst maximum; no AR issued to slave before prior RLast handshake.
REQ-028 New requests arriving in ADDR or DATA wait; they are evaluated on the IDLE cycle.
REQ-029 Minimum turnaround: one IDLE cycle between bursts.

Reset
REQ-030 ARESETn low asynchronously forces: FSM IDLE, grant 0, last_grant 1, len_reg 0, beat counter 0.
REQ-031 During reset all outputs 0: M*_ARReady, M*_RValid, S_ARValid, S_RReady, len_err, payload buses.
REQ-032 Reset mid-burst abandons transaction; no completion signalled to either master.
REQ-033 First cycle after deassert is IDLE; arbitration behaves as if M1 last granted.

Configuration
REQ-034 Macro ARB_RR_EN defined: round-robin; on simultaneous requests the master other than last_grant wins.
REQ-035 ARB_RR_EN undefined: fixed priority, M0 always wins simultaneous requests; last_grant still updated but unused.

Verification
REQ-036 Single M0 read ARAddr=0x1000, ARLen=3 -> S_ARID={4'd0,M0_ARID}, 4 beats routed to M0 only, RLast on beat 4, FSM IDLE after.
REQ-037 M0 and M1 request same cycle after reset, ARB_RR_EN defined -> M0 granted, then M1; repeat -> M0 again; undefined -> M0 both times while both request.
REQ-038 M1 burst ARLen=1 with M1_RReady held low 3 cycles on beat 2 -> S_RReady low those cycles, data held, no lost or duplicate beats.
REQ-039 Slave returns RLast on beat 2 for ARLen=3 -> len_err single pulse, FSM IDLE next cycle.
REQ-040 ARESETn asserted during DATA beat 2 -> all outputs 0 immediately (asynchronous), IDLE after release, next M1 request granted normally.
